// File: rtl/rv_opsel_pkg.sv
// Shared types for the operand-select stage: control bundle, op2 source encoding,
// and the sequential-PC increment.
package rv_opsel_pkg;

    localparam int unsigned PC_INCR = 4;

    typedef enum logic [1:0] {
        OP2_REG   = 2'd0,
        OP2_IMM_I = 2'd1,
        OP2_IMM_J = 2'd2,
        OP2_RSVD  = 2'd3
    } op2_sel_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       op1_pc;
        op2_sel_t   op2_sel;
        logic       jal;
        logic       jalr;
        logic       mret;
        logic       branch;
        logic       store;
        logic       reg_write;
        logic [2:0] funct3;
    } opsel_ctrl_t;

endpackage

// File: rtl/rv_fwd_mux.sv
// Resolves one source register value: x0 reads zero, otherwise the lowest-index
// matching forwarding source wins, falling back to register-file data.
module rv_fwd_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic [4:0]              i_idx,
    input  logic [XLEN-1:0]         i_reg_data,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD*5-1:0]    i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    output logic [XLEN-1:0]         o_value
);

    logic w_hit;

    always_comb begin
        o_value = i_reg_data;
        w_hit   = 1'b0;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (!w_hit && i_fwd_valid[k] && (i_fwd_rd[k*5 +: 5] == i_idx)) begin
                o_value = i_fwd_data[k*XLEN +: XLEN];
                w_hit   = 1'b1;
            end
        end
        if (i_idx == 5'd0) begin
            o_value = '0;
        end
    end

endmodule

// File: rtl/rv_opsel_stage.sv
// Operand-select pipeline stage: holds one decoded instruction and resolves its
// operands and jump target combinationally, with forwarding re-evaluated while stalled.
module rv_opsel_stage
    import rv_opsel_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned ZICSR   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_flush,
    input  opsel_ctrl_t             i_ctrl,
    input  logic [XLEN-1:0]         i_pc,
    input  logic [XLEN-1:0]         i_imm_i,
    input  logic [XLEN-1:0]         i_imm_j,
    input  logic [XLEN-1:0]         i_ret_addr,
    input  logic [XLEN-1:0]         i_reg1_data,
    input  logic [XLEN-1:0]         i_reg2_data,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD*5-1:0]    i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [4:0]              o_rs1,
    output logic [4:0]              o_rs2,
    output logic [XLEN-1:0]         o_op1,
    output logic [XLEN-1:0]         o_op2,
    output logic [XLEN-1:0]         o_reg_data2,
    output logic [XLEN-1:0]         o_pc_target,
    output logic [XLEN-1:0]         o_pc_p4,
    output logic [4:0]              o_rd,
    output logic [2:0]              o_funct3,
    output logic                    o_jump,
    output logic                    o_branch,
    output logic                    o_store,
    output logic                    o_reg_write,
    output logic [31:0]             o_stall_cnt
);

    logic                r_valid;
    opsel_ctrl_t         r_ctrl;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_imm_i;
    logic [XLEN-1:0]     r_imm_j;
    logic [31:0]         r_stall_cnt;

    logic                w_ready;
    logic                w_mret;
    logic [XLEN-1:0]     w_rs1_val;
    logic [XLEN-1:0]     w_rs2_val;
    logic [XLEN-1:0]     w_jalr_sum;

    assign w_ready = !r_valid || i_ready || i_flush;
    assign w_mret  = (ZICSR != 0) && r_ctrl.mret;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_valid && !i_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_ready) begin
                r_valid <= i_valid;
                if (i_valid) begin
                    r_ctrl  <= i_ctrl;
                    r_pc    <= i_pc;
                    r_imm_i <= i_imm_i;
                    r_imm_j <= i_imm_j;
                end
            end
        end
    end

    rv_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .i_idx       (r_ctrl.rs1),
        .i_reg_data  (i_reg1_data),
        .i_fwd_valid (i_fwd_valid),
        .i_fwd_rd    (i_fwd_rd),
        .i_fwd_data  (i_fwd_data),
        .o_value     (w_rs1_val)
    );

    rv_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .i_idx       (r_ctrl.rs2),
        .i_reg_data  (i_reg2_data),
        .i_fwd_valid (i_fwd_valid),
        .i_fwd_rd    (i_fwd_rd),
        .i_fwd_data  (i_fwd_data),
        .o_value     (w_rs2_val)
    );

    assign w_jalr_sum = w_rs1_val + r_imm_i;

    always_comb begin
        o_op1 = r_ctrl.op1_pc ? r_pc : w_rs1_val;
        case (r_ctrl.op2_sel)
            OP2_IMM_I: o_op2 = r_imm_i;
            OP2_IMM_J: o_op2 = r_imm_j;
            default:   o_op2 = w_rs2_val;
        endcase
        if (w_mret) begin
            o_pc_target = i_ret_addr;
        end else if (r_ctrl.jalr) begin
            o_pc_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            o_pc_target = r_pc + r_imm_j;
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = r_valid;
    assign o_rs1       = r_ctrl.rs1;
    assign o_rs2       = r_ctrl.rs2;
    assign o_reg_data2 = w_rs2_val;
    assign o_pc_p4     = r_pc + XLEN'(PC_INCR);
    assign o_rd        = r_ctrl.rd;
    assign o_funct3    = r_ctrl.funct3;
    assign o_jump      = r_valid && (r_ctrl.jal || r_ctrl.jalr || w_mret);
    assign o_branch    = r_valid && r_ctrl.branch;
    assign o_store     = r_valid && r_ctrl.store;
    assign o_reg_write = r_valid && r_ctrl.reg_write;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rv_opsel_stage.sv
// Scoreboard bench for rv_opsel_stage: expectations are queued at issue and compared
// when the held instruction is presented; a ZICSR=0 copy checks the mret-disabled path.
module tb_rv_opsel_stage;
    import rv_opsel_pkg::*;

    typedef struct packed {
        logic        v;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rd2;
        logic [31:0] tgt;
        logic [31:0] p4;
        logic        jump;
        logic        br;
        logic        st;
        logic        wr;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b1;
    opsel_ctrl_t ctrl = '0;
    logic [31:0] pc = '0, imm_i = '0, imm_j = '0, ret_addr = '0;
    logic [31:0] rf [32];
    logic [1:0]  fv = '0;
    logic [4:0]  frd [2];
    logic [31:0] fdat [2];

    logic [31:0] w_reg1, w_reg2;
    logic [9:0]  w_fwd_rd;
    logic [63:0] w_fwd_data;

    logic        o_ready, o_valid, o_jump, o_branch, o_store, o_reg_write;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_funct3;
    logic [31:0] o_op1, o_op2, o_reg_data2, o_pc_target, o_pc_p4, o_stall_cnt;

    logic        w0_ready, w0_valid, w0_jump, w0_branch, w0_store, w0_reg_write;
    logic [4:0]  w0_rs1, w0_rs2, w0_rd;
    logic [2:0]  w0_funct3;
    logic [31:0] w0_op1, w0_op2, w0_reg_data2, w0_pc_target, w0_pc_p4, w0_stall_cnt;

    obs_t sbq [$];
    int   n_pass = 0;
    int   n_total = 0;

    assign w_reg1     = rf[o_rs1];
    assign w_reg2     = rf[o_rs2];
    assign w_fwd_rd   = {frd[1], frd[0]};
    assign w_fwd_data = {fdat[1], fdat[0]};

    always #5 clk = ~clk;

    rv_opsel_stage #(.XLEN(32), .NUM_FWD(2), .ZICSR(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_ctrl(ctrl), .i_pc(pc), .i_imm_i(imm_i), .i_imm_j(imm_j),
        .i_ret_addr(ret_addr), .i_reg1_data(w_reg1), .i_reg2_data(w_reg2),
        .i_fwd_valid(fv), .i_fwd_rd(w_fwd_rd), .i_fwd_data(w_fwd_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_op1(o_op1), .o_op2(o_op2), .o_reg_data2(o_reg_data2),
        .o_pc_target(o_pc_target), .o_pc_p4(o_pc_p4), .o_rd(o_rd), .o_funct3(o_funct3),
        .o_jump(o_jump), .o_branch(o_branch), .o_store(o_store),
        .o_reg_write(o_reg_write), .o_stall_cnt(o_stall_cnt)
    );

    rv_opsel_stage #(.XLEN(32), .NUM_FWD(2), .ZICSR(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(w0_ready),
        .i_flush(i_flush), .i_ctrl(ctrl), .i_pc(pc), .i_imm_i(imm_i), .i_imm_j(imm_j),
        .i_ret_addr(ret_addr), .i_reg1_data(w_reg1), .i_reg2_data(w_reg2),
        .i_fwd_valid(fv), .i_fwd_rd(w_fwd_rd), .i_fwd_data(w_fwd_data),
        .o_valid(w0_valid), .i_ready(i_ready), .o_rs1(w0_rs1), .o_rs2(w0_rs2),
        .o_op1(w0_op1), .o_op2(w0_op2), .o_reg_data2(w0_reg_data2),
        .o_pc_target(w0_pc_target), .o_pc_p4(w0_pc_p4), .o_rd(w0_rd), .o_funct3(w0_funct3),
        .o_jump(w0_jump), .o_branch(w0_branch), .o_store(w0_store),
        .o_reg_write(w0_reg_write), .o_stall_cnt(w0_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic opsel_ctrl_t mk(input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [4:0] rd, input logic op1pc,
                                       input op2_sel_t sel, input logic jal,
                                       input logic jalr, input logic mret, input logic wr);
        opsel_ctrl_t c;
        c = '0;
        c.rs1 = r1; c.rs2 = r2; c.rd = rd; c.op1_pc = op1pc; c.op2_sel = sel;
        c.jal = jal; c.jalr = jalr; c.mret = mret; c.reg_write = wr;
        return c;
    endfunction

    function automatic logic [31:0] fval(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        for (int k = 0; k < 2; k++)
            if (fv[k] && frd[k] == idx) return fdat[k];
        return rf[idx];
    endfunction

    function automatic obs_t model(input opsel_ctrl_t c, input logic [31:0] p,
                                   input logic [31:0] ii, input logic [31:0] ij);
        obs_t e;
        logic [31:0] v1, v2;
        v1 = fval(c.rs1);
        v2 = fval(c.rs2);
        e.v    = 1'b1;
        e.op1  = c.op1_pc ? p : v1;
        e.op2  = (c.op2_sel == OP2_IMM_I) ? ii : (c.op2_sel == OP2_IMM_J) ? ij : v2;
        e.rd2  = v2;
        e.tgt  = c.mret ? ret_addr : c.jalr ? ((v1 + ii) & ~32'd1) : (p + ij);
        e.p4   = p + 32'd4;
        e.jump = c.jal | c.jalr | c.mret;
        e.br   = c.branch;
        e.st   = c.store;
        e.wr   = c.reg_write;
        e.rd   = c.rd;
        e.f3   = c.funct3;
        return e;
    endfunction

    function automatic obs_t obs();
        return {o_valid, o_op1, o_op2, o_reg_data2, o_pc_target, o_pc_p4,
                o_jump, o_branch, o_store, o_reg_write, o_rd, o_funct3};
    endfunction

    function automatic obs_t sb_pop();
        if (sbq.size() == 0) return '0;
        return sbq.pop_front();
    endfunction

    task automatic issue(input opsel_ctrl_t c, input logic [31:0] p,
                         input logic [31:0] ii, input logic [31:0] ij);
        ctrl = c; pc = p; imm_i = ii; imm_j = ij; i_valid = 1'b1;
        sbq.push_back(model(c, p, ii, ij));
        step();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t a;
        rst_n = 1'b0; i_valid = 1'b1; i_flush = 1'b1;
        ctrl = mk(1, 2, 3, 0, OP2_REG, 1, 0, 0, 1);
        step(); step();
        n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
        n_total++; if (o_stall_cnt !== 32'd0) $display("FAIL reset_stall: got %h want 0", o_stall_cnt); else n_pass++;
        a = obs();
        n_total++; if ({a.jump, a.br, a.st, a.wr} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {a.jump, a.br, a.st, a.wr}); else n_pass++;
        rst_n = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        #1;
        n_total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else n_pass++;
    endtask

    task automatic test_alu();
        obs_t a, e;
        rf[1] = 32'd5; rf[2] = 32'd7; fv = 2'b00;
        ctrl = mk(1, 2, 3, 0, OP2_REG, 0, 0, 0, 1);
        ctrl.funct3 = 3'b000;
        pc = 32'h100; i_valid = 1'b1;
        #1;
        n_total++; if (o_valid !== 1'b0) $display("FAIL alu_pre_valid: got %b want 0", o_valid); else n_pass++;
        sbq.push_back(model(ctrl, pc, imm_i, imm_j));
        step();
        i_valid = 1'b0;
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL alu_add: got %h want %h", a, e); else n_pass++;
        n_total++; if (o_op1 !== 32'd5 || o_op2 !== 32'd7) $display("FAIL alu_ops: got %h,%h want 5,7", o_op1, o_op2); else n_pass++;
        step();
        n_total++; if ({o_valid, o_reg_write} !== 2'b00) $display("FAIL alu_drain: got %b want 00", {o_valid, o_reg_write}); else n_pass++;
    endtask

    task automatic test_forward();
        obs_t a, e;
        rf[4] = 32'h44; rf[9] = 32'h99;
        fv = 2'b11; frd[0] = 5'd4; frd[1] = 5'd4; fdat[0] = 32'hAA; fdat[1] = 32'hBB;
        issue(mk(4, 0, 5, 0, OP2_IMM_I, 0, 0, 0, 1), 32'h200, 32'h20, 32'h0);
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL fwd_prio: got %h want %h", a, e); else n_pass++;
        n_total++; if (o_op1 !== 32'hAA) $display("FAIL fwd_prio_op1: got %h want aa", o_op1); else n_pass++;
        frd[0] = 5'd0; frd[1] = 5'd0;
        issue(mk(0, 4, 5, 0, OP2_REG, 0, 0, 0, 1), 32'h204, 32'h0, 32'h0);
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL fwd_x0: got %h want %h", a, e); else n_pass++;
        n_total++; if (o_op1 !== 32'h0) $display("FAIL fwd_x0_op1: got %h want 0", o_op1); else n_pass++;
        fv = 2'b10; frd[0] = 5'd9; frd[1] = 5'd9;
        issue(mk(9, 9, 5, 0, OP2_IMM_J, 0, 0, 0, 1), 32'h208, 32'h0, 32'h30);
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL fwd_src1: got %h want %h", a, e); else n_pass++;
        fv = 2'b00;
        step();
    endtask

    task automatic test_jumps();
        obs_t a, e;
        rf[5] = 32'h1001;
        issue(mk(5, 0, 1, 0, OP2_REG, 0, 1, 0, 1), 32'h2000, 32'd2, 32'd0);
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL jalr: got %h want %h", a, e); else n_pass++;
        n_total++; if (o_pc_target !== 32'h1002) $display("FAIL jalr_tgt: got %h want 1002", o_pc_target); else n_pass++;
        issue(mk(0, 0, 1, 1, OP2_IMM_J, 1, 0, 0, 1), 32'hFFFF_FFFC, 32'd0, 32'd8);
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL jal_wrap: got %h want %h", a, e); else n_pass++;
        n_total++; if (o_pc_target !== 32'h4 || o_pc_p4 !== 32'h0) $display("FAIL jal_wrap_pc: got %h,%h want 4,0", o_pc_target, o_pc_p4); else n_pass++;
        ret_addr = 32'h80;
        issue(mk(0, 0, 0, 0, OP2_REG, 0, 0, 1, 0), 32'h300, 32'd0, 32'h10);
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL mret: got %h want %h", a, e); else n_pass++;
        n_total++; if (w0_pc_target !== 32'h310 || w0_jump !== 1'b0) $display("FAIL mret_nozicsr: got %h,%b want 310,0", w0_pc_target, w0_jump); else n_pass++;
        step();
    endtask

    task automatic test_stall();
        obs_t a, e;
        rf[1] = 32'd5; rf[6] = 32'h66; fv = 2'b00;
        i_ready = 1'b1;
        issue(mk(1, 6, 7, 0, OP2_REG, 0, 0, 0, 1), 32'h400, 32'd0, 32'd0);
        i_ready = 1'b0;
        ctrl = mk(2, 3, 9, 0, OP2_REG, 1, 0, 0, 1); pc = 32'hDEAD_0000; i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fv = 2'b01; frd[0] = 5'd6; fdat[0] = 32'h100 + i;
            #1;
            n_total++; if (o_op2 !== (32'h100 + i) || o_ready !== 1'b0) $display("FAIL stall_track%0d: got %h,%b want %h,0", i, o_op2, o_ready, 32'h100 + i); else n_pass++;
            step();
        end
        n_total++; if (o_stall_cnt !== 32'd3) $display("FAIL stall_cnt: got %0d want 3", o_stall_cnt); else n_pass++;
        i_valid = 1'b0; fv = 2'b00;
        #1;
        a = obs(); e = sb_pop();
        n_total++; if (a !== e) $display("FAIL stall_hold: got %h want %h", a, e); else n_pass++;
    endtask

    task automatic test_flush();
        i_flush = 1'b1; i_valid = 1'b1;
        ctrl = mk(0, 0, 8, 0, OP2_REG, 1, 0, 0, 1);
        #1;
        n_total++; if (o_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", o_ready); else n_pass++;
        step();
        n_total++; if ({o_valid, o_jump, o_reg_write} !== 3'b000) $display("FAIL flush_kill: got %b want 000", {o_valid, o_jump, o_reg_write}); else n_pass++;
        n_total++; if (o_stall_cnt !== 32'd4) $display("FAIL flush_cnt: got %0d want 4", o_stall_cnt); else n_pass++;
        i_flush = 1'b0; i_valid = 1'b0;
        step();
        n_total++; if (o_valid !== 1'b0) $display("FAIL flush_drop: got %b want 0", o_valid); else n_pass++;
        i_ready = 1'b1;
    endtask

    task automatic test_reset_mid_stall();
        obs_t e;
        issue(mk(1, 2, 3, 0, OP2_REG, 0, 0, 0, 1), 32'h500, 32'd0, 32'd0);
        e = sb_pop();
        i_ready = 1'b0;
        step(); step();
        n_total++; if (o_stall_cnt !== 32'd6 || o_valid !== 1'b1) $display("FAIL rst_pre: got %0d,%b want 6,1", o_stall_cnt, o_valid); else n_pass++;
        rst_n = 1'b0; i_valid = 1'b1;
        step();
        n_total++; if (o_valid !== 1'b0 || o_stall_cnt !== 32'd0) $display("FAIL rst_mid: got %b,%0d want 0,0", o_valid, o_stall_cnt); else n_pass++;
        rst_n = 1'b1; i_valid = 1'b0;
        #1;
        n_total++; if (o_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_ready); else n_pass++;
        step();
        n_total++; if (o_valid !== 1'b0) $display("FAIL rst_discard: got %b want 0", o_valid); else n_pass++;
        i_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        obs_t a, e;
        opsel_ctrl_t c;
        for (int n = 0; n < 8; n++) begin
            c = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), op2_sel_t'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            c.branch = 1'($urandom_range(0, 1));
            c.store  = 1'($urandom_range(0, 1));
            c.funct3 = 3'($urandom_range(0, 7));
            rf[c.rs1] = $urandom; rf[c.rs2] = $urandom;
            fv = 2'($urandom_range(0, 3));
            frd[0] = (n % 2 == 0) ? c.rs1 : c.rs2; frd[1] = c.rs1;
            fdat[0] = $urandom; fdat[1] = $urandom;
            issue(c, $urandom, $urandom, $urandom);
            a = obs(); e = sb_pop();
            n_total++; if (a !== e) $display("FAIL b2b%0d: got %h want %h", n, a, e); else n_pass++;
        end
        fv = 2'b00;
        step();
        n_total++; if (o_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", o_valid); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        frd[0] = '0; frd[1] = '0; fdat[0] = '0; fdat[1] = '0;
        test_reset();
        test_alu();
        test_forward();
        test_jumps();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
